register_file_banked: RTL and testbench

REGISTER_FILE_BANKED -- requirements
Module: register_file_banked

---
 rtl/register_file_banked.sv | 115 +++++++++++
 tb/tb_register_file_banked.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_banked.sv
// Banked register file with combinational read ports, a program-counter register and a
// bank-switch handshake; every bank is zeroed by a walking counter after reset.
module register_file_banked #(
    parameter int WORD       = 16,
    parameter int REGISTERS  = 8,
    parameter int READ_PORTS = 2,
    parameter int BANKS      = 2,
    parameter int PC         = 7,
    parameter int BYPASS     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [WORD/8-1:0]            wren_i,
    input  logic [$clog2(REGISTERS)-1:0] wraddr_i,
    input  logic [WORD-1:0]              data_i,
    input  logic [$clog2(REGISTERS)-1:0] rdaddr_i [READ_PORTS],
    output logic [WORD-1:0]              data_o [READ_PORTS],
    input  logic                         pcen_i,
    input  logic                         pcinc_i,
    input  logic [WORD-1:0]              pc_i,
    output logic [WORD-1:0]              pc_o,
    input  logic                         bank_req_i,
    input  logic [$clog2(BANKS)-1:0]     bank_sel_i,
    output logic                         bank_ack_o,
    output logic [$clog2(BANKS)-1:0]     bank_o,
    output logic                         busy_o
);

    localparam int AW    = $clog2(REGISTERS);
    localparam int BW    = $clog2(BANKS);
    localparam int NB    = WORD / 8;
    localparam int DEPTH = BANKS * REGISTERS;
    localparam logic [AW-1:0] PC_IDX = AW'(PC);
    localparam bit BYP = (BYPASS != 0);

    typedef enum logic [1:0] {CLEAR, IDLE, SWITCH, ACK} state_t;

    state_t               state, state_next;
    logic [AW+BW-1:0]     clr_cnt;
    logic [BW-1:0]        bank_pend;
    logic [WORD-1:0]      mem [DEPTH];

    logic                 access_ok, wr_any, pc_load, pc_inc;
    logic [WORD-1:0]      byte_mask, wr_old, wr_merged, pc_cur;

    // State register; the reset branch also aborts any switch in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= CLEAR;
        else       state <= state_next;
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_cnt == '1) state_next = IDLE;
            IDLE:    if (bank_req_i)    state_next = SWITCH;
            SWITCH:                     state_next = ACK;
            ACK:     if (!bank_req_i)   state_next = IDLE;
            default:                    state_next = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_cnt   <= '0;
            bank_pend <= '0;
            bank_o    <= '0;
        end else begin
            if (state == CLEAR) clr_cnt <= clr_cnt + (AW+BW)'(1);
            if (state == IDLE && bank_req_i) bank_pend <= bank_sel_i;
            if (state == SWITCH) bank_o <= bank_pend;
        end
    end

    assign access_ok  = (state == IDLE) || (state == ACK);
    assign wr_any     = access_ok && (|wren_i);
    assign pc_load    = access_ok && !(|wren_i) && pcen_i;
    assign pc_inc     = access_ok && !(|wren_i) && !pcen_i && pcinc_i;
    assign busy_o     = (state == CLEAR) || (state == SWITCH);
    assign bank_ack_o = (state == ACK);

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < NB; b++) byte_mask[b*8 +: 8] = {8{wren_i[b]}};
    end

    assign wr_old    = mem[{bank_o, wraddr_i}];
    assign wr_merged = (wr_old & ~byte_mask) | (data_i & byte_mask);
    assign pc_cur    = mem[{bank_o, PC_IDX}];

    // NOTE: storage has no reset branch; it is zeroed by the CLEAR walk so it can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == CLEAR) mem[clr_cnt]             <= '0;
            else if (wr_any)    mem[{bank_o, wraddr_i}] <= wr_merged;
            else if (pc_load)   mem[{bank_o, PC_IDX}]   <= pc_i;
            else if (pc_inc)    mem[{bank_o, PC_IDX}]   <= pc_cur + WORD'(2);
        end
    end

    // Forwarding covers byte writes only; PC load/increment become visible after the edge.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            data_o[p] = mem[{bank_o, rdaddr_i[p]}];
            if (BYP && wr_any && rdaddr_i[p] == wraddr_i) data_o[p] = wr_merged;
            if (state == CLEAR) data_o[p] = '0;
        end
        pc_o = pc_cur;
        if (BYP && wr_any && wraddr_i == PC_IDX) pc_o = wr_merged;
        if (state == CLEAR) pc_o = '0;
    end

endmodule

// File: tb/tb_register_file_banked.sv
// Randomized bench for register_file_banked: a cycle-level behavioural model is compared
// against every output each cycle, plus directed scenarios with literal expectations.
module tb_register_file_banked;

    localparam int WORD = 16;
    localparam int REGS = 8;
    localparam int RP   = 2;
    localparam int BANKS = 2;
    localparam int PCI  = 7;
    localparam int CLEAR_CYCLES = BANKS * REGS;

    logic            clk;
    logic            rst;
    logic [1:0]      wren;
    logic [2:0]      wraddr;
    logic [WORD-1:0] data;
    logic [2:0]      rdaddr [RP];
    logic [WORD-1:0] rdata  [RP];
    logic            pcen, pcinc;
    logic [WORD-1:0] pc_in, pc_out;
    logic            bank_req;
    logic [0:0]      bank_sel;
    logic            bank_ack;
    logic [0:0]      bank;
    logic            busy;

    int tests = 0;
    int fails = 0;

    register_file_banked dut (
        .clk_i(clk), .rst_i(rst), .wren_i(wren), .wraddr_i(wraddr), .data_i(data),
        .rdaddr_i(rdaddr), .data_o(rdata), .pcen_i(pcen), .pcinc_i(pcinc),
        .pc_i(pc_in), .pc_o(pc_out), .bank_req_i(bank_req), .bank_sel_i(bank_sel),
        .bank_ack_o(bank_ack), .bank_o(bank), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: remaining clear cycles, switch/ack flags, active and pending bank.
    bit              m_valid = 0;
    int              m_clear_left;
    bit              m_switching, m_acking;
    int              m_bank, m_pend;
    logic [WORD-1:0] m_mem [BANKS][REGS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD-1:0] merge_bytes(input logic [WORD-1:0] old_v,
                                                    input logic [WORD-1:0] new_v,
                                                    input logic [1:0] en);
        logic [WORD-1:0] r;
        r = old_v;
        if (en[0]) r[7:0]  = new_v[7:0];
        if (en[1]) r[15:8] = new_v[15:8];
        return r;
    endfunction

    function automatic bit m_access();
        return m_clear_left == 0 && !m_switching;
    endfunction

    function automatic logic [WORD-1:0] m_read(input logic [2:0] a);
        if (m_clear_left > 0) return '0;
        if (m_access() && wren != 0 && a == wraddr)
            return merge_bytes(m_mem[m_bank][a], data, wren);
        return m_mem[m_bank][a];
    endfunction

    task automatic compare_all();
        if (!m_valid) return;
        check("busy", 64'(busy), 64'(m_clear_left > 0 || m_switching));
        check("bank_ack", 64'(bank_ack), 64'(m_acking));
        check("bank", 64'(bank), 64'(m_bank));
        for (int p = 0; p < RP; p++)
            check($sformatf("data_o%0d", p), 64'(rdata[p]), 64'(m_read(rdaddr[p])));
        check("pc_o", 64'(pc_out), 64'(m_read(3'(PCI))));
    endtask

    task automatic model_edge();
        if (rst) begin
            m_valid = 1; m_clear_left = CLEAR_CYCLES;
            m_switching = 0; m_acking = 0; m_bank = 0; m_pend = 0;
            return;
        end
        if (!m_valid) return;
        if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0)
                for (int b = 0; b < BANKS; b++)
                    for (int r = 0; r < REGS; r++) m_mem[b][r] = '0;
            return;
        end
        if (m_switching) begin
            m_switching = 0; m_bank = m_pend; m_acking = 1;
            return;
        end
        if (wren != 0)
            m_mem[m_bank][wraddr] = merge_bytes(m_mem[m_bank][wraddr], data, wren);
        else if (pcen)
            m_mem[m_bank][PCI] = pc_in;
        else if (pcinc)
            m_mem[m_bank][PCI] = m_mem[m_bank][PCI] + 16'd2;
        if (m_acking) begin
            if (!bank_req) m_acking = 0;
        end else if (bank_req) begin
            m_pend = int'(bank_sel); m_switching = 1;
        end
    endtask

    // One cycle: inputs already driven after a negedge; compare, take the edge, update model.
    task automatic tick();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; wren = '0; wraddr = '0; data = '0; pcen = 0; pcinc = 0; pc_in = '0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        check(name, 64'(n), 64'(16));
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (!bank_ack && n < 10) begin tick(); n++; end
        check(name, 64'(n), 64'(2));
    endtask

    initial begin
        idle_inputs();
        bank_req = 0; bank_sel = '0;
        rdaddr[0] = '0; rdaddr[1] = '0;
        @(negedge clk);

        // Reset, then busy for exactly the clear walk; everything reads zero afterwards.
        rst = 1; wren = 2'b11; wraddr = 3'd2; data = 16'hDEAD;
        tick();
        idle_inputs();
        count_busy("clear_busy_cycles");
        rdaddr[0] = 3'd2; rdaddr[1] = 3'd7;
        #1 check("after_clear_r2", 64'(rdata[0]), 64'h0);
        check("after_clear_pc", 64'(pc_out), 64'h0);

        // Byte-merge write with same-cycle forwarding.
        rdaddr[0] = 3'd3;
        wren = 2'b11; wraddr = 3'd3; data = 16'h1234;
        tick();
        wren = 2'b10; data = 16'hAB00;
        #1 check("bypass_merge", 64'(rdata[0]), 64'hAB34);
        tick();
        idle_inputs();
        #1 check("r3_after_merge", 64'(rdata[0]), 64'hAB34);

        // PC load, increment wrap, and write-over-PC-load priority.
        pcen = 1; pc_in = 16'hFFFE;
        tick();
        pcen = 0; pcinc = 1;
        #1 check("pc_loaded", 64'(pc_out), 64'hFFFE);
        tick();
        idle_inputs();
        #1 check("pc_wrap", 64'(pc_out), 64'h0000);
        wren = 2'b11; wraddr = 3'd1; data = 16'h1111; pcen = 1; pc_in = 16'h4444;
        tick();
        idle_inputs();
        rdaddr[1] = 3'd1;
        #1 check("pc_load_dropped", 64'(pc_out), 64'h0000);
        check("write_won", 64'(rdata[1]), 64'h1111);

        // Bank isolation across a full handshake in each direction.
        wren = 2'b11; wraddr = 3'd1; data = 16'h5555;
        tick();
        idle_inputs();
        bank_req = 1; bank_sel = 1'b1;
        wait_ack("ack_latency_b1");
        #1 check("bank_is_1", 64'(bank), 64'h1);
        check("b1_r1_zero", 64'(rdata[1]), 64'h0);
        bank_req = 0;
        tick();
        bank_req = 1; bank_sel = 1'b0;
        wait_ack("ack_latency_b0");
        bank_req = 0;
        tick();
        #1 check("b0_r1_kept", 64'(rdata[1]), 64'h5555);

        // Same-bank request still completes the handshake.
        bank_req = 1; bank_sel = 1'b0;
        wait_ack("ack_latency_same");
        #1 check("same_bank", 64'(bank), 64'h0);
        bank_req = 0;
        tick();

        // Reset during SWITCH; request held high through CLEAR is serviced on entry to IDLE.
        bank_req = 1; bank_sel = 1'b1;
        tick();
        #1 check("in_switch", 64'(busy), 64'h1);
        rst = 1;
        tick();
        rst = 0;
        #1 check("abort_bank", 64'(bank), 64'h0);
        check("abort_ack", 64'(bank_ack), 64'h0);
        count_busy("restart_busy_cycles");
        tick();
        #1 check("switch_after_clear", 64'(busy), 64'h1);
        tick();
        #1 check("ack_after_clear", 64'(bank_ack), 64'h1);
        check("bank_after_clear", 64'(bank), 64'h1);
        for (int i = 0; i < 3; i++) tick();
        #1 check("ack_held", 64'(bank_ack), 64'h1);
        bank_req = 0;
        tick();
        #1 check("ack_dropped", 64'(bank_ack), 64'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 499) == 0);
            wren     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            wraddr   = 3'($urandom);
            data     = 16'($urandom);
            pcen     = ($urandom_range(0, 7) == 0);
            pcinc    = ($urandom_range(0, 3) == 0);
            pc_in    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            rdaddr[0] = ($urandom_range(0, 1) == 0) ? wraddr : 3'($urandom);
            rdaddr[1] = 3'($urandom);
            if ($urandom_range(0, 9) == 0) bank_req = ~bank_req;
            bank_sel = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
